// File: rtl/settings_bus_pkg.sv
// Shared types and helpers for the settings bus arbiter.
package settings_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Response payload returned to a master on a write acknowledge
  localparam logic [63:0] RSP_DATA_ON_WRITE = 64'h0;

  // Master-index width: clog2 of the master count, never below one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or above
// the pointer wins, otherwise the lowest requesting index overall.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_c_o,
  output logic [IW-1:0] idx_c_o,
  output logic          any_c_o
);

  logic hi_found_c;

  always_comb begin
    gnt_c_o    = '0;
    idx_c_o    = '0;
    any_c_o    = 1'b0;
    hi_found_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!hi_found_c && req_i[i] && (32'(i) >= 32'(ptr_i))) begin
        hi_found_c = 1'b1;
        gnt_c_o[i] = 1'b1;
        idx_c_o    = IW'(i);
      end
    end
    // Wrap to the bottom of the vector when nothing sits at or above the pointer
    for (int unsigned i = 0; i < N; i++) begin
      if (!hi_found_c && !any_c_o && req_i[i]) begin
        any_c_o    = 1'b1;
        gnt_c_o[i] = 1'b1;
        idx_c_o    = IW'(i);
      end
    end
    if (hi_found_c) begin
      any_c_o = 1'b1;
    end
  end

endmodule

// File: rtl/settings_bus_arbiter.sv
// Round-robin arbiter sharing the single-master settings bus among
// several requesters; one transaction (accept, strobe, respond) at a time.
module settings_bus_arbiter
  import settings_bus_pkg::*;
#(
  parameter int unsigned C_DATAWIDTH   = 32,
  parameter int unsigned C_ADDRWIDTH   = 32,
  parameter int unsigned C_NUM_MASTERS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [C_NUM_MASTERS-1:0]             req_valid,
  output logic [C_NUM_MASTERS-1:0]             req_ready,
  input  logic [C_NUM_MASTERS-1:0]             req_write,
  input  logic [C_NUM_MASTERS*C_ADDRWIDTH-1:0] req_addr,
  input  logic [C_NUM_MASTERS*C_DATAWIDTH-1:0] req_data,
  output logic [C_NUM_MASTERS-1:0]             rsp_valid,
  input  logic [C_NUM_MASTERS-1:0]             rsp_ready,
  output logic [C_DATAWIDTH-1:0]               rsp_data,
  output logic                                 set_stb,
  output logic [C_ADDRWIDTH-1:0]               set_addr,
  output logic [C_DATAWIDTH-1:0]               set_data,
  output logic                                 get_stb,
  output logic [C_ADDRWIDTH-1:0]               get_addr,
  input  logic [C_DATAWIDTH-1:0]               get_data
);

  localparam int unsigned N  = C_NUM_MASTERS;
  localparam int unsigned AW = C_ADDRWIDTH;
  localparam int unsigned DW = C_DATAWIDTH;
  localparam int unsigned IW = idx_width(C_NUM_MASTERS);

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic            wr_q, wr_d;
  logic            set_stb_q, set_stb_d;
  logic            get_stb_q, get_stb_d;
  logic [AW-1:0]   set_addr_q, set_addr_d;
  logic [AW-1:0]   get_addr_q, get_addr_d;
  logic [DW-1:0]   set_data_q, set_data_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [N-1:0]    rsp_valid_q, rsp_valid_d;

  logic [N-1:0]    gnt_c;
  logic [IW-1:0]   gnt_idx_c;
  logic            gnt_any_c;
  logic            win_write_c;
  logic [AW-1:0]   win_addr_c;
  logic [DW-1:0]   win_data_c;

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_c_o (gnt_c),
    .idx_c_o (gnt_idx_c),
    .any_c_o (gnt_any_c)
  );

  // Select the winning master's request fields
  always_comb begin
    win_write_c = 1'b0;
    win_addr_c  = '0;
    win_data_c  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_c[i]) begin
        win_write_c = req_write[i];
        win_addr_c  = req_addr[i*AW +: AW];
        win_data_c  = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    wr_d        = wr_q;
    set_stb_d   = 1'b0;
    get_stb_d   = 1'b0;
    set_addr_d  = set_addr_q;
    get_addr_d  = get_addr_q;
    set_data_d  = set_data_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any_c) begin
          req_ready = gnt_c;
          win_d     = gnt_idx_c;
          wr_d      = win_write_c;
          // Strobe registers load here so the strobe appears in the ISSUE cycle
          if (win_write_c) begin
            set_stb_d  = 1'b1;
            set_addr_d = win_addr_c;
            set_data_d = win_data_c;
          end else begin
            get_stb_d  = 1'b1;
            get_addr_d = win_addr_c;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rsp_data_d  = wr_q ? DW'(RSP_DATA_ON_WRITE) : get_data;
        rsp_valid_d = N'(1) << win_q;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready[win_q]) begin
          rsp_valid_d = '0;
          rr_ptr_d    = (win_q == IW'(N - 1)) ? '0 : win_q + IW'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      wr_q        <= 1'b0;
      set_stb_q   <= 1'b0;
      get_stb_q   <= 1'b0;
      set_addr_q  <= '0;
      get_addr_q  <= '0;
      set_data_q  <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      wr_q        <= wr_d;
      set_stb_q   <= set_stb_d;
      get_stb_q   <= get_stb_d;
      set_addr_q  <= set_addr_d;
      get_addr_q  <= get_addr_d;
      set_data_q  <= set_data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign set_stb   = set_stb_q;
  assign get_stb   = get_stb_q;
  assign set_addr  = set_addr_q;
  assign get_addr  = get_addr_q;
  assign set_data  = set_data_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_settings_bus_arbiter.sv
// Bench for settings_bus_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_settings_bus_arbiter;

  localparam int unsigned M  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [31:0] ID_WORD = 32'hACE0BA53;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [M-1:0]    req_valid = '0;
  logic [M-1:0]    req_ready;
  logic [M-1:0]    req_write = '0;
  logic [M*AW-1:0] req_addr = '0;
  logic [M*DW-1:0] req_data = '0;
  logic [M-1:0]    rsp_valid;
  logic [M-1:0]    rsp_ready = '0;
  logic [DW-1:0]   rsp_data;
  logic            set_stb, get_stb;
  logic [AW-1:0]   set_addr, get_addr;
  logic [DW-1:0]   set_data, get_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  settings_bus_arbiter #(
    .C_DATAWIDTH   (DW),
    .C_ADDRWIDTH   (AW),
    .C_NUM_MASTERS (M)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .set_stb   (set_stb),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .get_stb   (get_stb),
    .get_addr  (get_addr),
    .get_data  (get_data)
  );

  // Settings block stand-in: word 0 is a read-only ID, words 1..15 are storage
  logic [31:0] env_mem [16];
  logic        env_init = 1'b0;
  assign get_data = (get_addr[5:2] == 4'd0) ? ID_WORD : env_mem[get_addr[5:2]];
  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= '0;
      env_init <= 1'b1;
    end else if (set_stb) begin
      env_mem[set_addr[5:2]] <= set_data;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // m_age: 0 = no transaction, 1 = strobe cycle, 2 = response pending
  int            m_age, m_own, m_ptr, mw;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rsp;
  logic [DW-1:0] mm [16];

  function automatic int pick(input logic [M-1:0] v, input int p);
    for (int k = 0; k < M; k++) begin
      if (v[(p + k) % M]) return (p + k) % M;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] sread(input logic [AW-1:0] a);
    return (a[5:2] == 4'd0) ? ID_WORD : mm[a[5:2]];
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mm[i] = '0;
    m_age = 0; m_ptr = 0; m_own = 0; mw = -1;
    m_wr = 1'b0; m_addr = '0; m_data = '0; m_rsp = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_age = 0; m_ptr = 0; m_rsp = '0;
      end else if (m_age == 0) begin
        mw = pick(req_valid, m_ptr);
        if (mw >= 0) begin
          m_own  = mw;
          m_wr   = req_write[mw];
          m_addr = req_addr[mw*AW +: AW];
          m_data = req_data[mw*DW +: DW];
          m_age  = 1;
        end
      end else if (m_age == 1) begin
        if (m_wr) begin
          mm[m_addr[5:2]] = m_data;
          m_rsp = '0;
        end else begin
          m_rsp = sread(m_addr);
        end
        m_age = 2;
      end else if (rsp_ready[m_own]) begin
        m_ptr = (m_own + 1) % M;
        m_age = 0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    logic [M-1:0] er;
    int w;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_set_stb", set_stb, 0);
      chk("rst_get_stb", get_stb, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_set_addr", set_addr, 0);
      chk("rst_get_addr", get_addr, 0);
      chk("rst_set_data", set_data, 0);
    end else begin
      w  = (m_age == 0) ? pick(req_valid, m_ptr) : -1;
      er = (w >= 0) ? (M'(1) << w) : '0;
      chk("req_ready", req_ready, er);
      chk("set_stb", set_stb, (m_age == 1) && m_wr);
      chk("get_stb", get_stb, (m_age == 1) && !m_wr);
      chk("rsp_valid", rsp_valid, (m_age == 2) ? (M'(1) << m_own) : M'(0));
      if (m_age == 1 && m_wr) begin
        chk("set_addr", set_addr, m_addr);
        chk("set_data", set_data, m_data);
      end
      if (m_age == 1 && !m_wr) chk("get_addr", get_addr, m_addr);
      if (m_age == 2) chk("rsp_data", rsp_data, m_rsp);
    end
  end

  // Observation: strobe count/spacing and grant order
  int            cyc = 0;
  int            n_set = 0;
  int            last_strobe = -100;
  int            min_gap = 1000;
  logic [AW-1:0] last_sa = '0;
  logic [DW-1:0] last_sd = '0;
  int            g_q [$];

  always @(negedge clk) begin : mon
    cyc++;
    if (rst_n && (set_stb || get_stb)) begin
      if (cyc - last_strobe < min_gap) min_gap = cyc - last_strobe;
      last_strobe = cyc;
    end
    if (rst_n && set_stb) begin
      n_set++;
      last_sa = set_addr;
      last_sd = set_data;
    end
    if (rst_n && req_ready != '0) begin
      for (int i = 0; i < M; i++) if (req_ready[i]) g_q.push_back(i);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int m, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_write[m]         = w;
    req_addr[m*AW +: AW] = a;
    req_data[m*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    repeat (4) tick();
    rsp_ready = '0;
  endtask

  task automatic do_txn(input int m, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output logic [DW-1:0] rd);
    bit got;
    rd = '0;
    set_req(m, w, a, d);
    req_valid[m] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      got = req_ready[m];
      tick();
    end
    req_valid[m] = 1'b0;
    chk("txn_accept", got, 1);
    got = 1'b0;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid[m]) begin
        got = 1'b1;
        rd  = rsp_data;
      end
    end
    chk("txn_response", got, 1);
    tick();
    rsp_ready[m] = 1'b1;
    tick();
    rsp_ready[m] = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [DW-1:0] rd;
    logic [M-1:0]  pend, g;
    int            n0;

    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_strobes", {set_stb, get_stb}, 0);
    tick();

    // Single read of the ID word by master 0
    set_req(0, 1'b0, 32'h0, 32'h0);
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("rd_accept", req_ready, 3'b001);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rd_get_stb", get_stb, 1);
    chk("rd_get_addr", get_addr, 0);
    chk("rd_no_rsp_yet", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("rd_rsp_valid", rsp_valid, 3'b001);
    chk("rd_rsp_data", rsp_data, 32'hACE0BA53);
    tick();
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    chk("rd_rsp_done", rsp_valid, 0);
    tick();

    // Write then read back by master 1
    n0 = n_set;
    do_txn(1, 1'b1, 32'h4, 32'h5, rd);
    chk("wr_ack_data", rd, 0);
    do_txn(1, 1'b0, 32'h4, 32'h0, rd);
    chk("wr_one_strobe", n_set - n0, 1);
    chk("wr_strobe_addr", last_sa, 32'h4);
    chk("wr_strobe_data", last_sd, 32'h5);
    chk("wr_readback", rd, 32'h5);

    // Contention from reset: masters 0 and 1 request continuously
    do_reset();
    g_q.delete();
    set_req(0, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b1, 32'h14, 32'hA5);
    req_valid = 3'b011;
    rsp_ready = 3'b011;
    repeat (14) tick();
    drain();
    chk("cont_grants", g_q.size() >= 4, 1);
    for (int i = 0; i < 4 && i < g_q.size(); i++)
      chk($sformatf("cont_grant%0d", i), g_q[i], i % 2);

    // Response backpressure on master 0 while master 1 waits
    do_reset();
    set_req(0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b1, 32'h20, 32'h1234);
    req_valid = 3'b011;
    @(negedge clk);
    chk("bp_first", req_ready, 3'b001);
    tick();
    req_valid[0] = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 3'b001);
      chk("bp_hold_data", rsp_data, 32'hACE0BA53);
      chk("bp_other_wait", req_ready, 0);
      tick();
    end
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    chk("bp_next", req_ready, 3'b010);
    tick();
    req_valid[1] = 1'b0;
    tick();
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;

    // Reset during the strobe cycle of a write
    set_req(0, 1'b1, 32'h8, 32'h77);
    req_valid = 3'b001;
    @(negedge clk);
    chk("mid_accept", req_ready, 3'b001);
    tick();
    req_valid = '0;
    chk("mid_set_stb", set_stb, 1);
    n0 = n_set;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_stb_drop", set_stb, 0);
    chk("mid_rsp_drop", rsp_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("mid_no_strobe", n_set - n0, 0);
    set_req(0, 1'b0, 32'h8, 32'h0);
    set_req(2, 1'b0, 32'h8, 32'h0);
    req_valid = 3'b101;
    @(negedge clk);
    chk("mid_ptr_zero", req_ready, 3'b001);
    tick();
    drain();
    do_txn(1, 1'b0, 32'h8, 32'h0, rd);
    chk("mid_no_partial", rd, 0);

    // Pointer wrap after master 2 is served
    do_txn(2, 1'b0, 32'h14, 32'h0, rd);
    chk("wrap_m2_data", rd, 32'hA5);
    set_req(0, 1'b0, 32'h4, 32'h0);
    set_req(2, 1'b0, 32'h4, 32'h0);
    req_valid = 3'b101;
    @(negedge clk);
    chk("wrap_grant0", req_ready, 3'b001);
    tick();
    drain();

    // Randomized traffic with withdrawals and response backpressure
    pend = '0;
    repeat (3000) begin
      @(negedge clk);
      g = req_ready;
      tick();
      for (int i = 0; i < M; i++) begin
        if (g[i]) pend[i] = 1'b0;
        else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15) * 4),
                  DW'($urandom));
        end
      end
      req_valid = pend;
      rsp_ready = M'($urandom_range(0, 7));
    end
    drain();
    repeat (2) tick();

    chk("strobe_spacing", min_gap >= 3, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/settings_bus_arbiter.md
# settings_bus_arbiter

Shares the single-master settings bus (set_stb/set_addr/set_data write port, get_stb/get_addr/get_data read port) of the accelerator's global settings register file among C_NUM_MASTERS requesters, e.g. the host AXI-lite bridge and on-chip DMA stream sequencers. One transaction at a time; round-robin grant. Sits between requesters and the settings block. Returns a per-requester response carrying read data or a write acknowledge.

## Interface
- C_DATAWIDTH, 32, settings data width
- C_ADDRWIDTH, 32, settings byte-address width
- C_NUM_MASTERS, 2, number of requesters (2..8)
- clk  in  1  sole clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  C_NUM_MASTERS  request pending, one bit per master
- req_ready  out  C_NUM_MASTERS  request accepted this cycle (one-hot or zero)
- req_write  in  C_NUM_MASTERS  1 = write, 0 = read
- req_addr  in  C_NUM_MASTERS*C_ADDRWIDTH  byte address, master i at slice i
- req_data  in  C_NUM_MASTERS*C_DATAWIDTH  write data, master i at slice i
- rsp_valid  out  C_NUM_MASTERS  response available (one-hot or zero)
- rsp_ready  in  C_NUM_MASTERS  master accepts response
- rsp_data  out  C_DATAWIDTH  read data; 0 for write acks; shared by all masters
- set_stb / set_addr / set_data  out  1 / C_ADDRWIDTH / C_DATAWIDTH  settings write port
- get_stb / get_addr  out  1 / C_ADDRWIDTH  settings read port
- get_data  in  C_DATAWIDTH  combinational read data from settings block

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any req_valid, pick winner by round-robin from pointer rr_ptr (lowest index at or above rr_ptr, wrapping). Same cycle: req_ready[winner]=1; latch winner index, write flag, address, data. Go ISSUE. No valid: stay.
- ISSUE (exactly one cycle): write → set_stb=1 with latched addr/data; read → get_stb=1 with latched addr, capture get_data into rsp_data register at cycle end. Go RESP.
- RESP: rsp_valid[winner]=1, rsp_data held (0 for writes). On rsp_ready[winner]: rr_ptr ← winner+1 mod C_NUM_MASTERS, go IDLE. Otherwise hold indefinitely; other masters wait.
- Masters keep req_valid/req_write/req_addr/req_data stable until req_ready; dropping valid before grant is legal (no transaction).
- Address passed unmodified; decoding/alignment is the settings block's job. Writes to settings word 0 (soft reset) are forwarded like any other write; arbiter is unaffected by soft_reset.
- Only one of set_stb/get_stb is ever high; both low outside ISSUE.

## Timing
- Reset (rst_n low, async): state IDLE, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_data 0, set_stb 0, get_stb 0, set/get addr 0, set_data 0. Outputs registered except req_ready (combinational from IDLE state and req_valid).
- Request accept cycle T0 → strobe at T1 → rsp_valid at T2. Minimum 3 cycles per transaction; next accept earliest cycle after rsp handshake.
- Simultaneous requests: pointer rule decides; a continuously requesting master waits at most C_NUM_MASTERS-1 transactions.
- rr_ptr update only on response handshake; wraps from C_NUM_MASTERS-1 to 0.
- Reset asserted mid-transaction: strobes and rsp_valid drop immediately; in-flight transaction lost; no partial write after reset release.
- rsp_ready asserted by non-winner: ignored.

## Structure
- Package settings_bus_pkg: state enum (IDLE/ISSUE/RESP), response-data-on-write constant (0), master-index width function (clog2 of C_NUM_MASTERS, min 1).
- Sub-module rr_arbiter: combinational round-robin picker (req vector + pointer → one-hot grant + index). Reused elsewhere in the accelerator.
- Top: FSM, latches, strobe generation, response register.

## Test plan
- Single read: master 0 reads addr 0x0 → get_stb one cycle with get_addr 0x0; rsp_valid[0] two cycles after accept, rsp_data 0xACE0BA53.
- Write then read: master 1 writes 0x5 to 0x4, then reads 0x4 → exactly one set_stb (addr 0x4, data 0x5), then rsp_data 0x5.
- Contention: both masters request every cycle from reset → grants alternate 0,1,0,1; no two strobes closer than 3 cycles.
- Response backpressure: rsp_ready[0] low 10 cycles → rsp_valid[0] and rsp_data held; master 1 req_ready stays 0 until handshake.
- Reset mid-op: rst_n low during ISSUE of a write → set_stb falls immediately; after release no strobe, rr_ptr 0, all outputs at reset values.
- Withdrawn request and wrap: C_NUM_MASTERS=3, master 2 served, then masters 0 and 2 request → master 0 granted (pointer wrapped).
